// File: rtl/stopwatch.sv
// stopwatch: up-counting MM:SS stopwatch (00:00 .. 99:59) with lap freeze and
// overflow detection.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-low reset
//   CE          count enable; prescaler and digits hold while low
//   start_stop  single-cycle pulse, toggles run/pause
//   lap         single-cycle pulse, toggles display freeze
//   clear       single-cycle pulse, back to 00:00 and IDLE
//   D3..D0      displayed BCD digits (min tens, min units, sec tens, sec units)
//   running     high while in RUN
//   lap_active  high while the display shows the frozen lap value
//   LED         overflow indicator, high in DONE
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | cleared, waiting for start_stop
// S_RUN   | prescaler counts, digits advance once per DIV enabled cycles
// S_PAUSE | counting suspended, partial second kept in the prescaler
// S_DONE  | 99:59 overflowed; only clear/reset leave this state

module stopwatch #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] D3,
  output logic [3:0] D2,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       running,
  output logic       lap_active,
  output logic       LED
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   cnt_q, cnt_d;   // {m1, m0, s1, s0}
  logic [15:0]   lap_q, lap_d;
  logic          lap_act_q, lap_act_d;
  logic          run_q, run_d;
  logic          led_q, led_d;

  logic tick;
  logic at_max;
  logic ovf;

  assign tick   = (state_q == S_RUN) && CE && (pre_q == PRE_MAX);
  assign at_max = (cnt_q == 16'h9959);
  assign ovf    = tick && at_max;

  // One-second BCD increment with carries s0 -> s1 -> m0 -> m1. Never called
  // at 99:59, so m1 cannot wrap.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      lap_q     <= '0;
      lap_act_q <= 1'b0;
      run_q     <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      run_q     <= run_d;
      led_q     <= led_d;
    end
  end

  // Next state: clear > overflow > start_stop
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (ovf) begin
      state_d = S_DONE;
    end else if (start_stop) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Registered flags are precomputed from the next state
  always_comb begin
    run_d = (state_d == S_RUN);
    led_d = (state_d == S_DONE);
  end

  // Prescaler, digits and lap capture
  always_comb begin
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;

    if (clear) begin
      pre_d     = '0;
      cnt_d     = '0;
      lap_d     = '0;
      lap_act_d = 1'b0;
    end else begin
      // A fresh start discards any stale phase; PAUSE->RUN keeps it.
      if (state_q == S_IDLE && state_d == S_RUN) begin
        pre_d = '0;
      end else if (state_q == S_RUN && CE) begin
        pre_d = tick ? '0 : pre_q + PW'(1);
      end

      if (tick && !at_max) begin
        cnt_d = bcd_inc(cnt_q);
      end

      // Capture uses cnt_q, i.e. the pre-increment value on a tick cycle.
      if (lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
        lap_act_d = !lap_act_q;
        if (!lap_act_q) begin
          lap_d = cnt_q;
        end
      end

      // Show the final 99:59 rather than a frozen lap.
      if (ovf) begin
        lap_act_d = 1'b0;
      end
    end
  end

  assign {D3, D2, D1, D0} = lap_act_q ? lap_q : cnt_q;
  assign running          = run_q;
  assign lap_active       = lap_act_q;
  assign LED              = led_q;

endmodule

// File: tb/tb_stopwatch.sv
// tb_stopwatch: scoreboard bench for stopwatch with DIV=4. A seconds-based
// reference model predicts the outputs of every cycle; the prediction is queued
// when the inputs are driven and popped after the following clock edge.

module tb_stopwatch;

  localparam int DIVT     = 4;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset, CE, start_stop, lap, clear;
  logic [3:0] D3, D2, D1, D0;
  logic       running, lap_active, LED;

  always #5 clk = ~clk;

  stopwatch #(.DIV(DIVT)) dut (
    .clk        (clk),
    .reset      (reset),
    .CE         (CE),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .D3         (D3),
    .D2         (D2),
    .D1         (D1),
    .D0         (D0),
    .running    (running),
    .lap_active (lap_active),
    .LED        (LED)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: elapsed time kept as plain seconds
  int m_state, m_sec, m_pre, m_lapsec;
  bit m_lapact;

  logic [18:0] exp_q[$];
  logic [18:0] prev_exp;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [18:0] model_out();
    logic [15:0] disp;
    disp = m_lapact ? to_bcd(m_lapsec) : to_bcd(m_sec);
    return {disp, (m_state == ST_RUN), m_lapact, (m_state == ST_DONE)};
  endfunction

  function automatic logic [18:0] dut_out();
    return {D3, D2, D1, D0, running, lap_active, LED};
  endfunction

  task automatic model_step(input bit rst, input bit ce, input bit ss,
                            input bit lp, input bit clr);
    bit tick, ovf;
    if (!rst || clr) begin
      m_state  = ST_IDLE;
      m_sec    = 0;
      m_pre    = 0;
      m_lapact = 0;
      m_lapsec = 0;
      return;
    end
    tick = (m_state == ST_RUN) && ce && (m_pre == DIVT - 1);
    ovf  = tick && (m_sec == 5999);
    if ((m_state == ST_RUN || m_state == ST_PAUSE) && lp) begin
      if (!m_lapact) m_lapsec = m_sec;
      m_lapact = !m_lapact;
    end
    if (m_state == ST_RUN && ce) m_pre = (m_pre + 1) % DIVT;
    if (tick && !ovf) m_sec++;
    if (ovf) begin
      m_state  = ST_DONE;
      m_lapact = 0;
    end else if (ss) begin
      case (m_state)
        ST_IDLE:  begin m_state = ST_RUN; m_pre = 0; end
        ST_RUN:   m_state = ST_PAUSE;
        ST_PAUSE: m_state = ST_RUN;
        default:  ;
      endcase
    end
  endtask

  // Called 1 time unit after a rising edge: drive, predict, confirm nothing
  // moves before the edge, then compare after the edge.
  task automatic step(input bit ce, input bit ss, input bit lp,
                      input bit clr, input bit rst);
    logic [18:0] e;
    CE         = ce;
    start_stop = ss;
    lap        = lp;
    clear      = clr;
    reset      = rst;
    model_step(rst, ce, ss, lp, clr);
    exp_q.push_back(model_out());
    #3;
    check_eq("pre_edge_hold", dut_out(), prev_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("cycle", dut_out(), e);
    prev_exp = e;
  endtask

  task automatic run(input int n);
    repeat (n) step(1, 0, 0, 0, 1);
  endtask

  task automatic disp_is(input string tag, input logic [15:0] v);
    check_eq(tag, {D3, D2, D1, D0}, v);
  endtask

  initial begin
    reset      = 1'b0;
    CE         = 1'b0;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    model_step(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_eq("reset_state", dut_out(), 19'd0);
    prev_exp = model_out();
    step(1, 0, 0, 0, 0);

    // Start and time 10 s
    step(1, 1, 0, 0, 1);
    run(40);
    check_eq("t10s_d1d0", {D1, D0}, 8'h10);
    check_eq("t10s_running", running, 1);

    // Minute carry, pause, resume with phase kept
    run(196);
    disp_is("at_0059", 16'h0059);
    run(4);
    disp_is("minute_carry", 16'h0100);
    run(2);
    step(1, 1, 0, 0, 1);
    run(20);
    disp_is("pause_hold", 16'h0100);
    check_eq("pause_running", running, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    disp_is("resume_phase", 16'h0101);

    // Clear together with start_stop, then lap freeze
    step(1, 1, 0, 1, 1);
    disp_is("clear_ss_disp", 16'h0000);
    check_eq("clear_ss_running", running, 0);
    step(1, 1, 0, 0, 1);
    run(20);
    step(1, 0, 1, 0, 1);
    run(12);
    disp_is("lap_frozen", 16'h0005);
    check_eq("lap_active_on", lap_active, 1);
    step(1, 0, 1, 0, 1);
    disp_is("lap_release", 16'h0008);
    check_eq("lap_active_off", lap_active, 0);

    // Lap on a tick captures pre-increment digits
    step(1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1);
    run(15);
    step(1, 0, 1, 0, 1);
    disp_is("lap_on_tick", 16'h0003);
    step(1, 0, 1, 0, 1);
    disp_is("live_after_tick", 16'h0004);
    run(2);
    // start_stop on a non-overflow tick: increment applied, then PAUSE
    step(1, 1, 0, 0, 1);
    disp_is("ss_on_tick_disp", 16'h0005);
    check_eq("ss_on_tick_running", running, 0);
    step(1, 1, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0, 1);
    disp_is("ce_low_hold", 16'h0005);
    run(4);
    disp_is("ce_resume", 16'h0006);

    // Reset at 12:34 with the display frozen
    step(1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1);
    run(3016);
    disp_is("at_1234", 16'h1234);
    step(1, 0, 1, 0, 1);
    run(3);
    disp_is("lap_1234", 16'h1234);
    check_eq("lap_1234_active", lap_active, 1);
    step(1, 1, 1, 0, 0);
    check_eq("mid_reset", dut_out(), 19'd0);

    // Overflow, with start_stop on the overflow tick
    step(1, 1, 0, 0, 1);
    run(23996);
    disp_is("at_9959", 16'h9959);
    run(3);
    step(1, 1, 0, 0, 1);
    check_eq("ovf_led", LED, 1);
    check_eq("ovf_running", running, 0);
    disp_is("ovf_disp", 16'h9959);
    step(1, 1, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    run(6);
    disp_is("done_disp", 16'h9959);
    check_eq("done_flags", {running, lap_active, LED}, 3'b001);
    step(1, 0, 0, 1, 1);
    check_eq("done_clear", dut_out(), 19'd0);
    step(1, 1, 0, 0, 1);
    check_eq("restart_running", running, 1);
    run(4);
    disp_is("restart_count", 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
